// File: rtl/seq_divmod.sv
// Iterative radix-2 restoring divider with AXI-stream operand/result handshakes.
// Define SEQ_DIVMOD_SIGNED_EN for two's-complement operands (adds one fix-up cycle).
module seq_divmod #(
  parameter int WIDTH = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tuser,
  output logic               m_axis_dout_tvalid,
  input  logic               m_axis_dout_tready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_dvd;   // dividend shifts out MSB first, quotient bits shift in at LSB
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic               r_ready;
  logic               r_valid;
  logic               r_user;
  logic [2*WIDTH-1:0] r_data;

  logic               w_accept;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_accept = r_ready & s_axis_dividend_tvalid & s_axis_divisor_tvalid;

  // Trial remainder is one bit wider than the operands so the compare cannot overflow.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift - {1'b0, r_dvs};

`ifdef SEQ_DIVMOD_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_a_orig;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // The most-negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign w_a_mag = s_axis_dividend_tdata[WIDTH-1] ? (~s_axis_dividend_tdata + WIDTH'(1))
                                                  : s_axis_dividend_tdata;
  assign w_b_mag = s_axis_divisor_tdata[WIDTH-1]  ? (~s_axis_divisor_tdata + WIDTH'(1))
                                                  : s_axis_divisor_tdata;
  assign w_q_fix = r_neg_q ? (~r_dvd + WIDTH'(1)) : r_dvd;
  assign w_r_fix = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
`else
  assign w_a_mag = s_axis_dividend_tdata;
  assign w_b_mag = s_axis_divisor_tdata;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_user  <= 1'b0;
      r_data  <= '0;
`ifdef SEQ_DIVMOD_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a_orig <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_CALC;
`ifdef SEQ_DIVMOD_SIGNED_EN
            r_neg_q  <= s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1];
            r_neg_r  <= s_axis_dividend_tdata[WIDTH-1];
            r_a_orig <= s_axis_dividend_tdata;
`endif
          end
        end

        S_CALC: begin
          if (r_cnt != CW'(WIDTH)) begin
            r_rem <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
          end else begin
`ifdef SEQ_DIVMOD_SIGNED_EN
            r_state <= S_FIX;
`else
            r_data  <= {r_dvd, r_rem};
            r_user  <= (r_dvs == '0);
            r_valid <= 1'b1;
            r_state <= S_DONE;
`endif
          end
        end

`ifdef SEQ_DIVMOD_SIGNED_EN
        S_FIX: begin
          // A zero divisor reports the raw dividend, not a sign-adjusted magnitude.
          if (r_dvs == '0) begin
            r_data <= {{WIDTH{1'b1}}, r_a_orig};
            r_user <= 1'b1;
          end else begin
            r_data <= {w_q_fix, w_r_fix};
            r_user <= 1'b0;
          end
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
`endif

        S_DONE: begin
          if (m_axis_dout_tready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign s_axis_dividend_tready = r_ready;
  assign s_axis_divisor_tready  = r_ready;
  assign m_axis_dout_tdata      = r_data;
  assign m_axis_dout_tuser      = r_user;
  assign m_axis_dout_tvalid     = r_valid;

endmodule

// File: tb/tb_seq_divmod.sv
// Directed self-checking bench for seq_divmod: reset, latency, divide-by-zero,
// backpressure, joint-accept handshake, mid-calculation reset and model-checked pairs.
module tb_seq_divmod;

  localparam int W = 40;
`ifdef SEQ_DIVMOD_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   dvd_data;
  logic           dvd_valid;
  logic           dvd_ready;
  logic [W-1:0]   dvs_data;
  logic           dvs_valid;
  logic           dvs_ready;
  logic [2*W-1:0] dout_data;
  logic           dout_user;
  logic           dout_valid;
  logic           dout_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  seq_divmod #(.WIDTH(W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tready (dvd_ready),
    .s_axis_divisor_tdata   (dvs_data),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tready  (dvs_ready),
    .m_axis_dout_tdata      (dout_data),
    .m_axis_dout_tuser      (dout_user),
    .m_axis_dout_tvalid     (dout_valid),
    .m_axis_dout_tready     (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {tuser, quotient, remainder} computed from the language's own operators.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_DIVMOD_SIGNED_EN
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic signed [W-1:0] sq;
    logic signed [W-1:0] sr;
    sa = a;
    sb = b;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {1'b0, a, {W{1'b0}}};
    sq = sa / sb;
    sr = sa % sb;
    return {1'b0, sq, sr};
`else
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, a / b, a % b};
`endif
  endfunction

  // Called at the negedge right after the accept edge; checks exact result latency.
  task automatic wait_result(input logic [W-1:0] eq, input logic [W-1:0] er, input logic eu,
                             input bit consume, input string tag);
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    check({tag, "_busy_readys"}, {dvd_ready, dvs_ready}, 2'b00);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check({tag, "_early_valid"}, dout_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, dout_valid, 1'b1);
    check({tag, "_quot"}, dout_data[2*W-1:W], eq);
    check({tag, "_rem"}, dout_data[W-1:0], er);
    check({tag, "_user"}, dout_user, eu);
    if (consume) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid_clr"}, dout_valid, 1'b0);
      check({tag, "_readys_back"}, {dvd_ready, dvs_ready}, 2'b11);
    end
  endtask

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    @(negedge clk);
    check({tag, "_idle_readys"}, {dvd_ready, dvs_ready}, 2'b11);
    dvd_data  = a;
    dvs_data  = b;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                     input logic [W-1:0] er, input logic eu, input bit consume, input string tag);
    offer(a, b, tag);
    wait_result(eq, er, eu, consume, tag);
  endtask

  initial begin
    logic [2*W:0]   exp_v;
    logic [2*W-1:0] held;
    logic [63:0]    rnd_a;
    logic [63:0]    rnd_b;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             ok;
    bit             seen;

    rst_n      = 1'b1;
    dvd_data   = '0;
    dvs_data   = '0;
    dvd_valid  = 1'b0;
    dvs_valid  = 1'b0;
    dout_ready = 1'b1;

    // Reset values, then held for 5 cycles
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", dout_valid, 1'b0);
    check("rst_data", dout_data, '0);
    check("rst_user", dout_user, 1'b0);
    check("rst_readys", {dvd_ready, dvs_ready}, 2'b11);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (dout_valid !== 1'b0 || dout_data !== '0 || dout_user !== 1'b0 ||
          {dvd_ready, dvs_ready} !== 2'b11) ok = 1'b0;
    end
    check("rst_hold", ok, 1'b1);
    rst_n = 1'b1;

    // Vectors valid in both arithmetic modes
    run(40'd100, 40'd7, 40'd14, 40'd2, 1'b0, 1'b1, "div_100_7");
    run(40'd12345, 40'd0, {W{1'b1}}, 40'd12345, 1'b1, 1'b1, "div_by_zero");
    run(40'd5, 40'd9, 40'd0, 40'd5, 1'b0, 1'b1, "div_small");

`ifdef SEQ_DIVMOD_SIGNED_EN
    run(-40'd7, 40'd2, -40'd3, -40'd1, 1'b0, 1'b1, "s_neg_pos");
    run(40'd7, -40'd2, -40'd3, 40'd1, 1'b0, 1'b1, "s_pos_neg");
    run(40'h80_0000_0000, {W{1'b1}}, 40'h80_0000_0000, 40'd0, 1'b0, 1'b1, "s_min_m1");
    run(-40'd12345, 40'd0, {W{1'b1}}, -40'd12345, 1'b1, 1'b1, "s_neg_by_zero");
`else
    run({W{1'b1}}, 40'd1, {W{1'b1}}, 40'd0, 1'b0, 1'b1, "div_max_1");
    run({W{1'b1}}, 40'h80_0000_0000, 40'd1, 40'h7F_FFFF_FFFF, 1'b0, 1'b1, "div_msb_dvs");
    run({W{1'b1}}, {W{1'b1}}, 40'd1, 40'd0, 1'b0, 1'b1, "div_max_max");
`endif

    // Backpressure: result held, new pair ignored until the result is taken
    dout_ready = 1'b0;
`ifdef SEQ_DIVMOD_SIGNED_EN
    run(40'h80_0000_0000, 40'd3, -40'd183251937962, -40'd2, 1'b0, 1'b0, "bp");
`else
    run(40'h80_0000_0000, 40'd3, 40'd183251937962, 40'd2, 1'b0, 1'b0, "bp");
`endif
    held      = dout_data;
    dvd_data  = 40'd100;
    dvs_data  = 40'd7;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (dout_data !== held || dout_valid !== 1'b1 || {dvd_ready, dvs_ready} !== 2'b00) ok = 1'b0;
    end
    check("bp_hold", ok, 1'b1);
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_taken_valid", dout_valid, 1'b0);
    check("bp_taken_readys", {dvd_ready, dvs_ready}, 2'b11);
    @(posedge clk);
    @(negedge clk);
    wait_result(40'd14, 40'd2, 1'b0, 1'b1, "bp_next");

    // Only the dividend is valid: nothing captured until the divisor joins
    dvd_data  = 40'd640;
    dvs_data  = 40'd32;
    dvd_valid = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if ({dvd_ready, dvs_ready} !== 2'b11 || dout_valid !== 1'b0) ok = 1'b0;
    end
    check("half_valid_no_capture", ok, 1'b1);
    dvs_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_result(40'd20, 40'd0, 1'b0, 1'b1, "joint");

    // Reset during the calculation discards the pending result
    offer(40'd1000000, 40'd1000, "abort");
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", dout_valid, 1'b0);
    check("abort_data", dout_data, '0);
    check("abort_readys", {dvd_ready, dvs_ready}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (dout_valid !== 1'b0) seen = 1'b1;
    end
    check("abort_no_result", seen, 1'b0);
    check("abort_readys_after", {dvd_ready, dvs_ready}, 2'b11);
    run(40'd1000000, 40'd1000, 40'd1000, 40'd0, 1'b0, 1'b1, "after_abort");

    // Pseudo-random pairs against the language operators
`ifdef SEQ_DIVMOD_SIGNED_EN
    for (int i = 0; i < 1000; i++) begin
`else
    for (int i = 0; i < 50; i++) begin
`endif
      rnd_a = {$urandom(), $urandom()};
      rnd_b = {$urandom(), $urandom()};
      a = rnd_a[W-1:0];
      b = rnd_b[W-1:0] >> $urandom_range(0, W - 1);
      exp_v = model(a, b);
      run(a, b, exp_v[2*W-1:W], exp_v[W-1:0], exp_v[2*W], 1'b1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
